// File: rtl/imem_boot_loader.sv
// Boot loader: streams a header/data/checksum image into byte-wide instruction
// memory and releases the core from reset once the checksum verifies.
module imem_boot_loader #(
    parameter int IMEM_BYTES     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic                            rx_ready,
    output logic                            mem_we,
    output logic [63:0]                     mem_addr,
    output logic [7:0]                      mem_wdata,
    output logic                            core_reset,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [1:0]                      err_code,
    output logic [$clog2(IMEM_BYTES):0]     bytes_loaded
);
    localparam int BLW = $clog2(IMEM_BYTES) + 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    state_t          state_q, state_d;
    logic [1:0]      err_q, err_d;
    logic [7:0]      acc_q, acc_d;
    logic [10:0]     len_q, len_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [BLW-1:0]  cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [63:0]     addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            busy_q, done_q, error_q, core_reset_q;

    logic            tmo_hit, xfer;
    logic [10:0]     hdr_len;

    // Timeout takes priority, so stop offering ready once it has fired.
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES));
    assign rx_ready = busy_q && !tmo_hit;
    assign xfer     = rx_valid && rx_ready;
    assign hdr_len  = {1'b0, rx_data, 2'b00};

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        acc_d   = acc_q;
        len_d   = len_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR;
                    err_d   = 2'd0;
                    acc_d   = 8'd0;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end
            end
            default: begin
                if (tmo_hit) begin
                    state_d = S_ERR;
                    err_d   = 2'd3;
                end else if (xfer) begin
                    tmo_d = '0;
                    if (state_q == S_HDR) begin
                        acc_d = rx_data;
                        len_d = hdr_len;
                        if (hdr_len > 11'(IMEM_BYTES)) begin
                            state_d = S_ERR;
                            err_d   = 2'd1;
                        end else if (rx_data == 8'd0) begin
                            state_d = S_CSUM;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else if (state_q == S_DATA) begin
                        we_d    = 1'b1;
                        addr_d  = 64'(cnt_q);
                        wdata_d = rx_data;
                        cnt_d   = cnt_q + 1'b1;
                        acc_d   = acc_q ^ rx_data;
                        if (32'(cnt_q) + 32'd1 == 32'(len_q))
                            state_d = S_CSUM;
                    end else begin
                        state_d = (rx_data == acc_q) ? S_DONE : S_ERR;
                        err_d   = (rx_data == acc_q) ? 2'd0 : 2'd2;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            err_q        <= 2'd0;
            acc_q        <= 8'd0;
            len_q        <= '0;
            tmo_q        <= '0;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= 64'd0;
            wdata_q      <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            acc_q        <= acc_d;
            len_q        <= len_d;
            tmo_q        <= tmo_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            busy_q       <= (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
            done_q       <= (state_d == S_DONE);
            error_q      <= (state_d == S_ERR);
            core_reset_q <= (state_d != S_DONE);
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign core_reset   = core_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_q;
    assign bytes_loaded = cnt_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader; expectations come from a stream-level
// model of the image format (header, data bytes, XOR checksum).
module tb_imem_boot_loader;
    localparam int IB  = 16;
    localparam int TO  = 8;
    localparam int BLW = $clog2(IB) + 1;

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [63:0] a; logic [7:0] d; } wr_t;

    logic            clk = 1'b0;
    logic            reset, start, rx_valid, rx_ready;
    logic [7:0]      rx_data, mem_wdata;
    logic            mem_we, core_reset, busy, done, error;
    logic [63:0]     mem_addr;
    logic [1:0]      err_code;
    logic [BLW-1:0]  bytes_loaded;

    int errs = 0;
    int checks = 0;
    wr_t wq[$];

    imem_boot_loader #(.IMEM_BYTES(IB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_reset(core_reset),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .bytes_loaded(bytes_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we === 1'b1) wq.push_back('{a: mem_addr, d: mem_wdata});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, ".mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, ".mem_addr"}, mem_addr, 64'd0);
        chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, ".core_reset"}, 64'(core_reset), 64'd1);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".error"}, 64'(error), 64'd0);
        chk({tag, ".err_code"}, 64'(err_code), 64'd0);
        chk({tag, ".bytes"}, 64'(bytes_loaded), 64'd0);
    endtask

    // Start pulse from IDLE/DONE/ERROR: the next cycle is a fresh HDR state.
    task automatic pulse_start(input string tag);
        @(negedge clk); start = 1'b1; rx_valid = 1'b0;
        @(negedge clk); start = 1'b0;
        chk({tag, ".st_busy"}, 64'(busy), 64'd1);
        chk({tag, ".st_core_reset"}, 64'(core_reset), 64'd1);
        chk({tag, ".st_flags"}, {62'd0, done, error}, 64'd0);
        chk({tag, ".st_err_code"}, 64'(err_code), 64'd0);
    endtask

    // gap: 0 back-to-back, 1 alternate cycles, 2 random bubbles.
    task automatic send(input bq_t s, input int gap, input string tag);
        int idx = 0;
        int cyc = 0;
        logic v;
        while (idx < s.size() && cyc < 200) begin
            @(negedge clk);
            cyc++;
            v = (gap == 0) ? 1'b1 : (gap == 1) ? cyc[0] : ($urandom % 3 != 0);
            rx_valid = v;
            rx_data  = v ? s[idx] : 8'($urandom);
            start    = busy && ($urandom % 8 == 0);
            if (v && rx_ready) idx++;
        end
        if (idx < s.size()) chk({tag, ".stall"}, 64'(idx), 64'(s.size()));
    endtask

    task automatic run_stream(input bq_t s, input int gap, input string tag);
        int n = int'(s[0]);
        int nb, ecode;
        logic [7:0] x;
        wr_t exp_w[$];
        int wn;
        if (4 * n > IB) begin
            ecode = 1; nb = 0;
        end else begin
            x = s[0];
            for (int k = 0; k < 4 * n; k++) begin
                exp_w.push_back('{a: 64'(k), d: s[k + 1]});
                x = x ^ s[k + 1];
            end
            ecode = (s[4 * n + 1] == x) ? 0 : 2;
            nb = 4 * n;
        end
        pulse_start(tag);
        wq.delete();
        send(s, gap, tag);
        @(negedge clk); rx_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        chk({tag, ".done"}, 64'(done), 64'(ecode == 0));
        chk({tag, ".error"}, 64'(error), 64'(ecode != 0));
        chk({tag, ".err_code"}, 64'(err_code), 64'(ecode));
        chk({tag, ".core_reset"}, 64'(core_reset), 64'(ecode != 0));
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".bytes"}, 64'(bytes_loaded), 64'(nb));
        chk({tag, ".nwrites"}, 64'(wq.size()), 64'(exp_w.size()));
        wn = (wq.size() < exp_w.size()) ? wq.size() : exp_w.size();
        for (int i = 0; i < wn; i++) begin
            chk({tag, ".waddr"}, wq[i].a, exp_w[i].a);
            chk({tag, ".wdata"}, 64'(wq[i].d), 64'(exp_w[i].d));
        end
        // Bytes offered while not ready must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rx_valid = 1'b1; rx_data = 8'($urandom);
        end
        @(negedge clk); rx_valid = 1'b0;
        chk({tag, ".hold_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, ".hold_flags"}, {62'd0, done, error}, {62'd0, ecode == 0, ecode != 0});
        chk({tag, ".hold_code"}, 64'(err_code), 64'(ecode));
        chk({tag, ".hold_writes"}, 64'(wq.size()), 64'(exp_w.size()));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t q;
        int n;
        logic [7:0] x;
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        q = '{8'h01, 8'h93, 8'h02, 8'h40, 8'h00, 8'hD0};
        run_stream(q, 0, "nominal");
        q = '{8'h05};
        run_stream(q, 0, "overflow");
        q = '{8'h01, 8'h93, 8'h02, 8'h40, 8'h00, 8'hD1};
        run_stream(q, 0, "csum_bad");
        q = '{8'h01, 8'h93, 8'h02, 8'h40, 8'h00, 8'hD0};
        run_stream(q, 1, "gapped");
        q = '{8'h00, 8'h00};
        run_stream(q, 0, "empty");
        q = '{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
              8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h04};
        run_stream(q, 0, "full");

        // Timeout after a header and one data byte.
        pulse_start("tmo");
        q = '{8'h01, 8'hAB};
        send(q, 0, "tmo");
        @(negedge clk); rx_valid = 1'b0; start = 1'b0;
        repeat (7) @(negedge clk);
        chk("tmo.early_error", 64'(error), 64'd0);
        chk("tmo.early_busy", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);
        chk("tmo.error", 64'(error), 64'd1);
        chk("tmo.err_code", 64'(err_code), 64'd3);
        chk("tmo.bytes", 64'(bytes_loaded), 64'd1);
        chk("tmo.core_reset", 64'(core_reset), 64'd1);

        // Reset in the middle of the data phase.
        pulse_start("midrst");
        q = '{8'h01, 8'h11, 8'h22};
        send(q, 0, "midrst");
        @(negedge clk); reset = 1'b1; rx_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset = 1'b0;
        q = '{8'h01, 8'h93, 8'h02, 8'h40, 8'h00, 8'hD0};
        run_stream(q, 0, "restart");
        pulse_start("redo");

        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(0, 5);
            q = '{8'(n)};
            x = 8'(n);
            if (n <= 4) begin
                for (int k = 0; k < 4 * n; k++) begin
                    q.push_back(8'($urandom));
                    x = x ^ q[k + 1];
                end
                q.push_back(($urandom % 4 == 0) ? 8'(x ^ 8'($urandom_range(1, 255))) : x);
            end
            run_stream(q, $urandom_range(0, 2), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time controller that fills the byte-addressed, little-endian instruction memory from a byte stream, then releases the pipeline core from reset.
- Sits between an external byte source (UART/JTAG shim or testbench) and the instruction memory write port.
- Holds the core in reset until a complete, checksum-verified image is written.

Parameters:
- IMEM_BYTES, 16, instruction memory size in bytes; must be a multiple of 4.
- TIMEOUT_CYCLES, 1024, idle cycles allowed between accepted bytes before the load aborts.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- rx_data  in  8  incoming stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready.
- mem_we  out  1  instruction memory byte write strobe.
- mem_addr  out  64  byte address, matching the fetch address width.
- mem_wdata  out  8  byte to write.
- core_reset  out  1  holds the pipeline in reset while high.
- busy  out  1  high in HDR, DATA and CSUM.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.
- err_code  out  2  error cause: 1 = length overflow, 2 = checksum mismatch, 3 = timeout; 0 otherwise.
- bytes_loaded  out  $clog2(IMEM_BYTES)+1  count of data bytes written.

Behaviour:
- Reset values:
  - state = IDLE.
  - rx_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - core_reset = 1, busy = 0, done = 0, error = 0, err_code = 0, bytes_loaded = 0.
  - Internal registers cleared: checksum accumulator, word count, timeout counter.
- Stream format:
  - Byte 0 is the header N = number of 32-bit words.
  - Then 4N data bytes in ascending address order. Byte k goes to address k, so byte 0 of each word is the LSB.
  - Then one checksum byte = XOR of the header and all data bytes.
- States:
  - IDLE: rx_ready = 0. On start, go to HDR and clear the accumulator, bytes_loaded and the timeout counter.
  - HDR: rx_ready = 1. On a transfer:
    - Load N and set the accumulator to the header byte.
    - If 4N > IMEM_BYTES, go to ERROR with code 1.
    - Else if N == 0, go to CSUM.
    - Else go to DATA.
  - DATA: rx_ready = 1. On a transfer of byte k:
    - Next cycle: mem_we = 1 for exactly one cycle, mem_addr = k, mem_wdata = the byte.
    - bytes_loaded increments, and the accumulator XORs in the byte.
    - After byte 4N-1 is accepted, go to CSUM.
  - CSUM: rx_ready = 1. On a transfer, compare the byte with the accumulator. Match goes to DONE; mismatch goes to ERROR with code 2.
  - DONE: rx_ready = 0, done = 1, core_reset = 0. Memory contents and bytes_loaded are held.
  - ERROR: rx_ready = 0, error = 1, core_reset = 1. err_code is held until the next start or reset.
- Latency: every state transition and every output update takes effect the cycle after the accepting transfer. The write for the last data byte completes no later than the cycle in which the checksum is accepted.
- Timeout:
  - In HDR, DATA and CSUM, the counter increments on every cycle without a transfer and clears on a transfer.
  - When the counter reaches TIMEOUT_CYCLES, go to ERROR with code 3 on the next cycle.
- start:
  - In DONE or ERROR, start re-enters HDR. core_reset rises to 1 and done, error and err_code clear on the same edge.
  - start in HDR, DATA or CSUM is ignored.
- rx_valid with rx_ready = 0 is ignored; no state change.
- Back-to-back transfers are supported at one byte per cycle, with no bubbles required.
- Bytes beyond IMEM_BYTES are never written; the header check guarantees this.
- reset asserted mid-load returns everything to the reset values on that edge. No further mem_we is issued; memory contents are unspecified.

Test Plan:
- Nominal load: start, then 0x01, 0x93, 0x02, 0x40, 0x00, 0xD0 back-to-back.
  -> mem_we pulses at addresses 0..3 with data 93, 02, 40, 00; done = 1; core_reset = 0; bytes_loaded = 4; err_code = 0.
- Length overflow: with IMEM_BYTES = 16, header 0x05.
  -> error = 1 and err_code = 1 the cycle after the header is accepted; no mem_we; core_reset = 1.
- Checksum mismatch: the nominal stream with checksum 0xD1.
  -> all four writes occur, then error = 1, err_code = 2, core_reset = 1, done = 0.
- Timeout: with TIMEOUT_CYCLES = 8, send header 0x01 and one data byte, then hold rx_valid = 0.
  -> ERROR with err_code = 3 after 8 idle cycles; bytes_loaded = 1.
- Gapped stream and empty image:
  - Nominal stream with rx_valid toggling every other cycle -> identical writes and DONE.
  - Header 0x00, checksum 0x00 -> DONE with no mem_we.
- Reset and restart:
  - Assert reset after 2 data bytes -> outputs return to reset values the next cycle.
  - start then the nominal stream -> DONE.
  - start from DONE -> core_reset reasserts the cycle after start.
